// File: rtl/data_break_arbiter_if.sv
// ============================================================================
//  data_break_arbiter_if : device / CPU state machine / memory signal bundle
//  Rev 1.0
// ============================================================================
`default_nettype none

interface data_break_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 15
);
    logic [NREQ-1:0]    req_i;
    logic [NREQ-1:0]    req_wr_i;
    logic [NREQ*AW-1:0] req_addr_i;
    logic [NREQ*12-1:0] req_wdata_i;
    logic [NREQ-1:0]    grant_o;
    logic [NREQ-1:0]    done_o;
    logic [11:0]        rdata_o;
    logic               data_break_o;
    logic               to_disk_o;
    logic               sm_db_go_i;
    logic               sm_db_end_i;
    logic [AW-1:0]      mem_addr_o;
    logic [11:0]        mem_wdata_o;
    logic               mem_we_o;
    logic [11:0]        mem_rdata_i;

    modport slave (
        input  req_i, req_wr_i, req_addr_i, req_wdata_i,
        input  sm_db_go_i, sm_db_end_i, mem_rdata_i,
        output grant_o, done_o, rdata_o, data_break_o, to_disk_o,
        output mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output req_i, req_wr_i, req_addr_i, req_wdata_i,
        output sm_db_go_i, sm_db_end_i, mem_rdata_i,
        input  grant_o, done_o, rdata_o, data_break_o, to_disk_o,
        input  mem_addr_o, mem_wdata_o, mem_we_o
    );
endinterface

`default_nettype wire

// File: rtl/data_break_arbiter.sv
// ============================================================================
//  data_break_arbiter : PDP-8/E data-break arbiter and memory port driver
//  Option macro DB_ROUND_ROBIN_EN selects round-robin (default fixed priority)
//  Rev 1.0
// ============================================================================
`default_nettype none

module data_break_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 15
) (
    input wire                   clk,
    input wire                   rst_n,
    data_break_arbiter_if.slave  bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_XFER = 3'd2,
        S_CAPT = 3'd3,
        S_WEND = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [11:0]     rdata_q, rdata_d;
    logic            db_q, db_d;
    logic            to_disk_q, to_disk_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [11:0]     mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [11:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;

    logic [IW-1:0]   win_idx;
    logic            win_vld;

`ifdef DB_ROUND_ROBIN_EN
    logic [IW-1:0]   ptr_q, ptr_d;

    // Descending scan so the candidate nearest ptr+1 is assigned last and wins.
    always_comb begin
        int cand;
        cand    = 0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = (int'(ptr_q) + k) % NREQ;
            if (bus.req_i[IW'(cand)]) begin
                win_idx = IW'(cand);
                win_vld = 1'b1;
            end
        end
    end

    assign ptr_d = (state_q == S_IDLE && win_vld) ? win_idx : ptr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= IW'(NREQ - 1);
        else        ptr_q <= ptr_d;
    end
`else
    always_comb begin
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (bus.req_i[IW'(i)]) begin
                win_idx = IW'(i);
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        db_d        = db_q;
        to_disk_d   = to_disk_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    grant_d   = NREQ'(1) << win_idx;
                    db_d      = 1'b1;
                    wr_d      = bus.req_wr_i[win_idx];
                    to_disk_d = ~bus.req_wr_i[win_idx];
                    addr_d    = bus.req_addr_i[win_idx*AW +: AW];
                    wdata_d   = bus.req_wdata_i[win_idx*12 +: 12];
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.sm_db_go_i) begin
                    db_d        = 1'b0;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = wdata_q;
                    mem_we_d    = wr_q;
                    state_d     = S_XFER;
                end
            end
            S_XFER: state_d = S_CAPT;
            // Memory data for the XFER address is valid during CAPT.
            S_CAPT: begin
                if (!wr_q) rdata_d = bus.mem_rdata_i;
                state_d = S_WEND;
            end
            S_WEND: begin
                if (bus.sm_db_end_i) begin
                    done_d  = grant_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            db_q        <= 1'b0;
            to_disk_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            db_q        <= db_d;
            to_disk_q   <= to_disk_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
        end
    end

    assign bus.grant_o      = grant_q;
    assign bus.done_o       = done_q;
    assign bus.rdata_o      = rdata_q;
    assign bus.data_break_o = db_q;
    assign bus.to_disk_o    = to_disk_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_wdata_o  = mem_wdata_q;
    assign bus.mem_we_o     = mem_we_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));

endmodule

`default_nettype wire
